ifu_fetch_ctrl: RTL

Instruction-fetch controller that sequences the combinational instruction ROM for the npc core.
- Owns the PC and drives the ROM address.
- Captures the returned instruction word into a 2-entry buffer.
- Hands instructions to decode over a valid/ready handshake.
- Handles redirects (branch/jump), halt, and out-of-range/misaligned fetch faults.

---
 rtl/ifu_pkg.sv | 32 +++
 rtl/ifu_fetch_ctrl_if.sv | 49 ++++
 rtl/ifu_fetch_buf.sv | 64 ++++++
 rtl/ifu_fetch_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
//   fetch_state_t : controller state, also exported on the debug port
//   fetch_entry_t : one output-buffer entry {pc, inst, fault}
//   fetch_addr_ok : true when a PC lies inside the ROM window and is word aligned
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h80000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  // The unsigned offset from the window base wraps to a huge value for
  // addresses below the base, so one compare covers both window edges.
  function automatic logic fetch_addr_ok(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] depth_words);
    logic [31:0] offset;
    offset = pc - base;
    return (offset < (depth_words << 2)) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-side bus of the instruction-fetch controller.
//   ROM port      : rom_addr (out), rom_data (in, combinational from rom_addr)
//   control       : redirect_valid, redirect_pc, halt
//   decode port   : out_valid/out_ready handshake with out_inst, out_pc, out_fault
//   debug         : fetch_state
// master = the fetch controller, slave = the ROM/decode/control environment.
interface ifu_fetch_ctrl_if;

  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [1:0]  fetch_state;

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_fault,
    output fetch_state
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_fault,
    input  fetch_state
  );

endinterface

// File: rtl/ifu_fetch_buf.sv
// Two-entry synchronous FIFO holding fetched entries for decode.
//   clk, rst  : clock and synchronous active-high reset
//   push      : write wr_entry (accepted when not full, or full with a pop)
//   pop       : drop the head (ignored when empty)
//   flush     : discard all entries; beats a same-cycle push
//   full/empty: occupancy flags
//   head      : oldest entry, straight from storage registers
module ifu_fetch_buf
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, the write slot is the slot being popped, so push+pop is safe.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assert property (@(posedge clk) disable iff (rst) (int'(count) <= DEPTH));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM at
// rom_addr = pc, and queues {pc, inst, fault} entries in a 2-entry buffer that
// decode drains over a valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ifu_fetch_ctrl_if.master (ROM, redirect/halt, decode, debug state)
// Priority: rst > redirect > halt > fault > normal fetch.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ROM_DEPTH = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  ifu_fetch_ctrl_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         addr_ok;
  logic         buf_push;
  logic         buf_pop;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign addr_ok = fetch_addr_ok(pc, RESET_PC, ROM_DEPTH);

  // Push decision: only in FETCH, never under redirect or halt, and only when
  // the buffer has room now or gains it through this cycle's pop.
  always_comb begin
    buf_pop    = !buf_empty && bus.out_ready;
    buf_push   = 1'b0;
    push_entry = '{pc: pc, inst: bus.rom_data, fault: 1'b0};
    if (state == FETCH && !bus.redirect_valid && !bus.halt && (!buf_full || buf_pop)) begin
      buf_push = 1'b1;
      if (!addr_ok) begin
        push_entry = '{pc: pc, inst: NOP_INST, fault: 1'b1};
      end
    end
  end

  // A fault entry is the last push: the PC stays on the faulting address and
  // the controller parks in HALT until a redirect restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_pc;
      state <= bus.halt ? HALT : FETCH;
    end else begin
      case (state)
        IDLE: state <= bus.halt ? HALT : FETCH;
        FETCH: begin
          if (bus.halt) begin
            state <= HALT;
          end else if (buf_push) begin
            if (addr_ok) begin
              pc <= pc + 32'd4;
            end else begin
              state <= HALT;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  ifu_fetch_buf #(
    .DEPTH(int'(BUF_DEPTH))
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (buf_push),
    .pop     (buf_pop),
    .flush   (bus.redirect_valid),
    .wr_entry(push_entry),
    .full    (buf_full),
    .empty   (buf_empty),
    .head    (head)
  );

  assign bus.rom_addr    = pc;
  assign bus.out_valid   = !buf_empty;
  assign bus.out_inst    = head.inst;
  assign bus.out_pc      = head.pc;
  assign bus.out_fault   = head.fault;
  assign bus.fetch_state = state;

endmodule
